mcu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle mcu.
- Register-file/memory microcontroller with a valid/ready request handshake, an iterative divider, shift and compare ops, and explicit divide-by-zero reporting.
- Sits between the command source (bench or host sequencer) and internal data memory.
- Executes one operation at a time; results are written back to memory and presented on out.

---
 rtl/mcu_pkg.sv | 39 +++
 rtl/mcu_divider.sv | 83 ++++++++
 rtl/mcu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mcu_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mcu_pkg
// Purpose  : Opcode and sequencer state encodings shared by mcu_seq blocks.
// Revision : 1.0
// ============================================================================
package mcu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_READ  = 4'd7,
        OP_WRITE = 4'd8,
        OP_SHL   = 4'd9,
        OP_SHR   = 4'd10,
        OP_LTU   = 4'd11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DIVIDE = 3'd3,
        WB     = 3'd4
    } state_e;

    localparam int OP_LAST = 11;

    function automatic logic op_is_valid(input logic [3:0] code);
        return code <= 4'(OP_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mcu_divider
// Purpose  : Unsigned restoring divider producing one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module mcu_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              busy_q, busy_d;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;

    assign trial = {rem_q, quo_q[DATA_W-1]};
    assign diff  = trial - {1'b0, dvs_q};

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CNT_W'(DATA_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!diff[DATA_W]) begin
                rem_d = diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            busy_q <= busy_d;
        end
    end

    // done flags the final iteration; quotient is settled on the following cycle.
    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient = quo_q;

endmodule
`default_nettype wire

// File: rtl/mcu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mcu_seq
// Purpose  : Multi-cycle memory-to-memory microcontroller with iterative divide.
// Revision : 1.0
// ============================================================================
module mcu_seq
    import mcu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] op0,
    input  logic [DATA_W-1:0] op1,
    input  logic [ADDR_W-1:0] op2,
    output logic [DATA_W-1:0] out,
    output logic              done,
    output logic              op_err,
    output logic              div_zero,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] op0_q, op0_d;
    logic [ADDR_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              err_q, err_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;
    logic              op_err_q, op_err_d;
    logic              div_zero_q, div_zero_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wb_data;
    logic [SHAMT_W-1:0] shamt;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quot;

    assign shamt = op1_q[SHAMT_W-1:0];

    mcu_divider #(
        .DATA_W (DATA_W)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (opa_q),
        .divisor  (opb_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        alu_res = out_q;
        case (opcode_e'(op_q))
            OP_ADD:   alu_res = opa_q + opb_q;
            OP_SUB:   alu_res = opa_q - opb_q;
            OP_MUL:   alu_res = opa_q * opb_q;
            OP_DIV:   alu_res = '1;
            OP_AND:   alu_res = opa_q & opb_q;
            OP_OR:    alu_res = opa_q | opb_q;
            OP_XOR:   alu_res = opa_q ^ opb_q;
            OP_READ:  alu_res = opa_q;
            OP_WRITE: alu_res = op1_q;
            OP_SHL:   alu_res = opa_q << shamt;
            OP_SHR:   alu_res = opa_q >> shamt;
            OP_LTU:   alu_res = {{(DATA_W-1){1'b0}}, (opa_q < opb_q)};
            default:  alu_res = out_q;
        endcase
    end

    // A successful divide takes its result from the divider, not the ALU.
    assign wb_data   = ((op_q == OP_DIV) && !dz_q) ? div_quot : res_q;
    assign mem_waddr = (op_q == OP_WRITE) ? op0_q : op2_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op0_d      = op0_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        res_d      = res_q;
        err_d      = err_q;
        dz_d       = dz_q;
        out_d      = out_q;
        done_d     = 1'b0;
        op_err_d   = op_err_q;
        div_zero_d = div_zero_q;
        div_start  = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = op;
                    op0_d   = op0;
                    op1_d   = op1;
                    op2_d   = op2;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                opa_d   = mem[op0_q];
                opb_d   = mem[op1_q[ADDR_W-1:0]];
                state_d = EXEC;
            end
            EXEC: begin
                res_d = alu_res;
                err_d = !op_is_valid(op_q);
                dz_d  = (op_q == OP_DIV) && (opb_q == '0);
                if ((op_q == OP_DIV) && (opb_q != '0)) begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end else begin
                    state_d = WB;
                end
            end
            DIVIDE: begin
                if (div_done || !div_busy) begin
                    state_d = WB;
                end
            end
            WB: begin
                done_d     = 1'b1;
                op_err_d   = err_q;
                div_zero_d = dz_q;
                if (!err_q) begin
                    out_d = wb_data;
                end
                mem_we  = !err_q && !dz_q && (op_q != OP_READ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            op0_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            dz_q       <= 1'b0;
            out_q      <= '0;
            done_q     <= 1'b0;
            op_err_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op0_q      <= op0_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            res_q      <= res_d;
            err_q      <= err_d;
            dz_q       <= dz_d;
            out_q      <= out_d;
            done_q     <= done_d;
            op_err_q   <= op_err_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Data memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wb_data;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign done      = done_q;
    assign op_err    = op_err_q;
    assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_seq
// Purpose  : Randomised and directed self-checking bench for mcu_seq.
// Revision : 1.0
// ============================================================================
module tb_mcu_seq;

    localparam int DIV_LAT = 32 + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  op = '0;
    logic [9:0]  op0 = '0;
    logic [31:0] op1 = '0;
    logic [9:0]  op2 = '0;
    logic [31:0] out;
    logic        done, op_err, div_zero, busy;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] model_out = '0;
    logic [31:0] g_out, m_out;
    logic        g_err, g_dz, m_err, m_dz;
    int          g_lat, m_lat;

    mcu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .op0       (op0),
        .op1       (op1),
        .op2       (op2),
        .out       (out),
        .done      (done),
        .op_err    (op_err),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference behaviour: plain arithmetic on a word array.
    task automatic model_op(input logic [3:0] o, input logic [9:0] a, input logic [31:0] b,
                            input logic [9:0] d);
        logic [31:0] x, y, r;
        bit wr;
        x = ref_mem[a];
        y = ref_mem[b[9:0]];
        m_err = 1'b0; m_dz = 1'b0; m_lat = 3; wr = 1'b1; r = '0;
        case (o)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x * y;
            4'd3:  if (y == 0) begin m_dz = 1'b1; r = 32'hFFFF_FFFF; wr = 1'b0; end
                   else begin r = x / y; m_lat = DIV_LAT; end
            4'd4:  r = x & y;
            4'd5:  r = x | y;
            4'd6:  r = x ^ y;
            4'd7:  begin r = x; wr = 1'b0; end
            4'd8:  begin r = b; ref_mem[a] = b; wr = 1'b0; end
            4'd9:  r = x << (b % 32);
            4'd10: r = x >> (b % 32);
            4'd11: r = (x < y) ? 32'd1 : 32'd0;
            default: begin m_err = 1'b1; r = model_out; wr = 1'b0; end
        endcase
        if (wr) ref_mem[d] = r;
        model_out = r;
        m_out = r;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [9:0] a, input logic [31:0] b,
                          input logic [9:0] d);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        op = o; op0 = a; op1 = b; op2 = d; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        g_lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                g_lat = k;
                break;
            end
        end
        g_out = out; g_err = op_err; g_dz = div_zero;
    endtask

    task automatic issue(input logic [3:0] o, input logic [9:0] a, input logic [31:0] b,
                         input logic [9:0] d);
        model_op(o, a, b, d);
        run_op(o, a, b, d);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_hs: busy=%b req_ready=%b want 0/1", busy, req_ready); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (out !== 32'd0) begin n_fail++;
            $display("FAIL reset_out: got %h want 0", out); end
        n_cmp++; if ({done, op_err, div_zero} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got %b want 000", {done, op_err, div_zero}); end
    endtask

    task automatic test_write_read();
        logic [31:0] want [4];
        want = '{32'd19, 32'd25, 32'd19, 32'd25};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: issue(4'd8, 10'd3, 32'd19, 10'd0);
                1: issue(4'd8, 10'd4, 32'd25, 10'd0);
                2: issue(4'd7, 10'd3, 32'd0, 10'd0);
                default: issue(4'd7, 10'd4, 32'd0, 10'd0);
            endcase
            n_cmp++; if (g_out !== want[i] || g_err !== 1'b0) begin n_fail++;
                $display("FAIL wr_rd[%0d]: got %h err=%b want %h err=0", i, g_out, g_err, want[i]); end
            n_cmp++; if (g_lat !== 3) begin n_fail++;
                $display("FAIL wr_rd_lat[%0d]: got %0d want 3", i, g_lat); end
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops  [7];
        logic [31:0] want [7];
        ops  = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd1};
        want = '{32'd44, 32'd6, 32'd475, 32'd17, 32'd27, 32'd10, 32'hFFFF_FFFA};
        for (int i = 0; i < 7; i++) begin
            if (i == 6) issue(ops[i], 10'd3, 32'd4, 10'(20 + i));
            else        issue(ops[i], 10'd4, 32'd3, 10'(20 + i));
            n_cmp++; if (g_out !== want[i] || g_lat !== 3) begin n_fail++;
                $display("FAIL alu[%0d]: got %h lat %0d want %h lat 3", i, g_out, g_lat, want[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            issue(4'd7, 10'(20 + i), 32'd0, 10'd0);
            n_cmp++; if (g_out !== want[i]) begin n_fail++;
                $display("FAIL alu_rd[%0d]: got %h want %h", i, g_out, want[i]); end
        end
    endtask

    task automatic test_divide();
        issue(4'd3, 10'd4, 32'd3, 10'd9);
        n_cmp++; if (g_out !== 32'd1 || g_lat !== DIV_LAT || g_dz !== 1'b0) begin n_fail++;
            $display("FAIL div: got %h lat %0d dz %b want 1 lat %0d dz 0", g_out, g_lat, g_dz, DIV_LAT); end
        issue(4'd7, 10'd9, 32'd0, 10'd0);
        n_cmp++; if (g_out !== 32'd1) begin n_fail++;
            $display("FAIL div_rd: got %h want 1", g_out); end
        issue(4'd8, 10'd5, 32'd0, 10'd0);
        issue(4'd8, 10'd13, 32'h0000_1234, 10'd0);
        issue(4'd3, 10'd4, 32'd5, 10'd13);
        n_cmp++; if (g_dz !== 1'b1 || g_out !== 32'hFFFF_FFFF || g_err !== 1'b0) begin n_fail++;
            $display("FAIL div0: got dz %b out %h err %b want 1 ffffffff 0", g_dz, g_out, g_err); end
        issue(4'd7, 10'd13, 32'd0, 10'd0);
        n_cmp++; if (g_out !== 32'h0000_1234 || g_dz !== 1'b0) begin n_fail++;
            $display("FAIL div0_rd: got %h dz %b want 00001234 dz 0", g_out, g_dz); end
    endtask

    task automatic test_shift_cmp();
        logic [3:0]  ops  [4];
        logic [31:0] bs   [4];
        logic [9:0]  as   [4];
        logic [31:0] want [4];
        ops  = '{4'd9, 4'd10, 4'd11, 4'd11};
        as   = '{10'd4, 10'd4, 10'd3, 10'd4};
        bs   = '{32'd2, 32'd3, 32'd4, 32'd3};
        want = '{32'd100, 32'd3, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 10'(14 + i));
            n_cmp++; if (g_out !== want[i]) begin n_fail++;
                $display("FAIL shcmp[%0d]: got %h want %h", i, g_out, want[i]); end
            issue(4'd7, 10'(14 + i), 32'd0, 10'd0);
            n_cmp++; if (g_out !== want[i]) begin n_fail++;
                $display("FAIL shcmp_rd[%0d]: got %h want %h", i, g_out, want[i]); end
        end
    endtask

    task automatic test_invalid();
        issue(4'd8, 10'd30, 32'h0000_CAFE, 10'd0);
        for (int i = 12; i < 16; i++) begin
            issue(4'(i), 10'd4, 32'd3, 10'd30);
            n_cmp++; if (g_err !== 1'b1 || g_out !== 32'h0000_CAFE || g_lat !== 3) begin n_fail++;
                $display("FAIL invalid[%0d]: err %b out %h lat %0d want 1 0000cafe 3", i, g_err, g_out, g_lat); end
        end
        issue(4'd7, 10'd30, 32'd0, 10'd0);
        n_cmp++; if (g_out !== 32'h0000_CAFE || g_err !== 1'b0) begin n_fail++;
            $display("FAIL invalid_rd: got %h err %b want 0000cafe 0", g_out, g_err); end
    endtask

    task automatic test_back_to_back();
        int first_ready, done_at, lat2, guard;
        logic [31:0] got1, want1;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
        model_op(4'd3, 10'd4, 32'd3, 10'd19);
        want1 = m_out;
        op = 4'd3; op0 = 10'd4; op1 = 32'd3; op2 = 10'd19; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = 4'd7; op0 = 10'd19; op1 = 32'd0; op2 = 10'd0;
        first_ready = -1; done_at = -1; got1 = '0;
        for (int k = 0; k < 100; k++) begin
            if (done && done_at < 0) begin done_at = k; got1 = out; end
            if (req_ready) begin first_ready = k; break; end
            @(negedge clk);
        end
        model_op(4'd7, 10'd19, 32'd0, 10'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat2 = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done) begin lat2 = k; break; end
        end
        n_cmp++; if (first_ready !== DIV_LAT || done_at !== DIV_LAT) begin n_fail++;
            $display("FAIL b2b_ready: ready at %0d done at %0d want %0d", first_ready, done_at, DIV_LAT); end
        n_cmp++; if (got1 !== want1) begin n_fail++;
            $display("FAIL b2b_div: got %h want %h", got1, want1); end
        n_cmp++; if (lat2 !== 3 || out !== m_out) begin n_fail++;
            $display("FAIL b2b_second: lat %0d out %h want 3 %h", lat2, out, m_out); end
    endtask

    task automatic test_reset_mid_divide();
        int guard;
        issue(4'd8, 10'd18, 32'h5A5A_5A5A, 10'd0);
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
        op = 4'd3; op0 = 10'd4; op1 = 32'd3; op2 = 10'd18; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || out !== 32'd0) begin n_fail++;
            $display("FAIL rst_mid: busy %b done %b ready %b out %h want 0 0 1 0", busy, done, req_ready, out); end
        model_out = '0;
        @(negedge clk);
        reset = 1'b0;
        issue(4'd8, 10'd21, 32'hDEAD_0021, 10'd0);
        issue(4'd7, 10'd21, 32'd0, 10'd0);
        n_cmp++; if (g_out !== 32'hDEAD_0021 || g_lat !== 3) begin n_fail++;
            $display("FAIL rst_wr_rd: got %h lat %0d want dead0021 3", g_out, g_lat); end
        issue(4'd7, 10'd18, 32'd0, 10'd0);
        n_cmp++; if (g_out !== 32'h5A5A_5A5A) begin n_fail++;
            $display("FAIL rst_keep: got %h want 5a5a5a5a", g_out); end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [9:0]  a, d;
        logic [31:0] b;
        for (int i = 0; i < 32; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            issue(4'd8, 10'(i), b, 10'd0);
            n_cmp++; if (g_out !== m_out) begin n_fail++;
                $display("FAIL rnd_init[%0d]: got %h want %h", i, g_out, m_out); end
        end
        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 15));
            a = 10'($urandom_range(0, 31));
            d = 10'($urandom_range(0, 31));
            if (o == 4'd8)
                b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            else if (o == 4'd9 || o == 4'd10)
                b = 32'($urandom_range(0, 63));
            else
                b = 32'($urandom_range(0, 31));
            issue(o, a, b, d);
            n_cmp++;
            if (g_out !== m_out || g_err !== m_err || g_dz !== m_dz || g_lat !== m_lat) begin
                n_fail++;
                $display("FAIL rnd[%0d] op %0d: out %h err %b dz %b lat %0d want %h %b %b %0d",
                         i, o, g_out, g_err, g_dz, g_lat, m_out, m_err, m_dz, m_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alu();
        test_divide();
        test_shift_cmp();
        test_invalid();
        test_back_to_back();
        test_reset_mid_divide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
